// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl
// Fetch-stage program counter sequencer with ID-stage branch resolution.
// Owns the PC register, picks the next PC (pc+4, resolved branch/jump
// target, or exception vector), and produces the IF/ID hold/flush and
// ID/EX bubble controls. A flow instruction in ID that depends on a result
// still in EX/MEM is held for a counted number of stall cycles.
//
// Handshake: imem_ready=1 means the fetch of the current pc completes this
// cycle; the PC only advances on such a cycle (or on an exception
// redirect, which always advances). When a redirect happens while a fetch
// is still in flight, the next ready beat belongs to the stale address and
// is discarded.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   imem_ready          current fetch completes this cycle
//   id_*                ID-stage flow instruction info (valid, is_flow,
//                       taken, target, source regs and their use flags)
//   ex_regwrite/ex_is_load/ex_rd   EX-stage producer info
//   mem_is_load/mem_rd  MEM-stage load producer info
//   exc_req             single-cycle exception redirect pulse
//   pc, pc_plus4        current fetch address and its sequential successor
//   if_id_write         IF/ID register enable
//   if_id_flush         IF/ID loads a bubble
//   id_ex_bubble        ID/EX loads a bubble
//   stall_cnt           remaining branch-hazard stall cycles
//   state_o             FSM state: 00 RUN, 01 HAZ, 10 DROP
module pc_flow_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter bit          DELAY_SLOT = 1'b1,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic        id_valid,
    input  logic        id_is_flow,
    input  logic        id_taken,
    input  logic [31:0] id_target,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_regwrite,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        mem_is_load,
    input  logic [4:0]  mem_rd,
    input  logic        exc_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [1:0]  stall_cnt,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HAZ  = 2'b01,
        DROP = 2'b10
    } state_t;

    state_t state;

    logic       flow;
    logic       rs_ex_hit;
    logic       rt_ex_hit;
    logic       rs_mem_hit;
    logic       rt_mem_hit;
    logic [1:0] depth;
    logic       hazard;

    assign flow = id_valid && id_is_flow;

    // Register 0 never creates a dependency.
    assign rs_ex_hit  = id_uses_rs && (id_rs != 5'd0) && ex_regwrite && (id_rs == ex_rd);
    assign rt_ex_hit  = id_uses_rt && (id_rt != 5'd0) && ex_regwrite && (id_rt == ex_rd);
    assign rs_mem_hit = id_uses_rs && (id_rs != 5'd0) && mem_is_load && (id_rs == mem_rd);
    assign rt_mem_hit = id_uses_rt && (id_rt != 5'd0) && mem_is_load && (id_rt == mem_rd);

    // A load still in EX needs two cycles before its data can be forwarded
    // to the ID comparator; an EX ALU result or a MEM load needs one.
    always_comb begin
        depth = 2'd0;
        if ((rs_ex_hit || rt_ex_hit) && ex_is_load)
            depth = 2'd2;
        else if (rs_ex_hit || rt_ex_hit || rs_mem_hit || rt_mem_hit)
            depth = 2'd1;
    end

    // Dependency checks only start a stall from RUN.
    assign hazard = (state == RUN) && flow && (depth != 2'd0);

    assign pc_plus4 = pc + 32'd4;
    assign state_o  = state;

    // Per-cycle pipeline controls, evaluated against the current inputs.
    always_comb begin
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (reset || exc_req) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        id_ex_bubble = 1'b1;
                    end else if (imem_ready) begin
                        if_id_write = 1'b1;
                        // Without a delay slot the sequential fetch behind a
                        // taken redirect must not enter ID.
                        if_id_flush = !DELAY_SLOT && flow && id_taken;
                    end
                end
                HAZ: begin
                    id_ex_bubble = 1'b1;
                end
                DROP: begin
                    // ID was already flushed by the redirect; keep it empty
                    // and throw away the stale beat when it arrives.
                    id_ex_bubble = 1'b1;
                    if_id_flush  = imem_ready;
                end
                default: begin
                    id_ex_bubble = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc        <= {RESET_PC[31:2], 2'b00};
            state     <= RUN;
            stall_cnt <= 2'd0;
        end else if (exc_req) begin
            pc        <= {EXC_VECTOR[31:2], 2'b00};
            stall_cnt <= 2'd0;
            state     <= imem_ready ? RUN : DROP;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        stall_cnt <= depth;
                        state     <= HAZ;
                    end else if (imem_ready) begin
                        if (flow && id_taken)
                            pc <= {id_target[31:2], 2'b00};
                        else
                            pc <= {pc_plus4[31:2], 2'b00};
                    end
                end
                HAZ: begin
                    if (stall_cnt <= 2'd1) begin
                        stall_cnt <= 2'd0;
                        state     <= RUN;
                    end else begin
                        stall_cnt <= stall_cnt - 2'd1;
                    end
                end
                DROP: begin
                    if (imem_ready)
                        state <= RUN;
                end
                default: begin
                    state     <= RUN;
                    stall_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
module tb_pc_flow_ctrl;

    logic        clock;
    logic        reset;
    logic        imem_ready;
    logic        id_valid;
    logic        id_is_flow;
    logic        id_taken;
    logic [31:0] id_target;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        ex_regwrite;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        mem_is_load;
    logic [4:0]  mem_rd;
    logic        exc_req;

    logic [31:0] pc, pc_plus4;
    logic        if_id_write, if_id_flush, id_ex_bubble;
    logic [1:0]  stall_cnt, state_o;

    // Second instance without delay slot; only its flush output differs.
    logic [31:0] pc_n, pc_plus4_n;
    logic        if_id_write_n, if_id_flush_n, id_ex_bubble_n;
    logic [1:0]  stall_cnt_n, state_n;

    int passed;
    int total;

    pc_flow_ctrl #(.DELAY_SLOT(1'b1)) dut (
        .clock(clock), .reset(reset), .imem_ready(imem_ready),
        .id_valid(id_valid), .id_is_flow(id_is_flow), .id_taken(id_taken),
        .id_target(id_target), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_is_load(mem_is_load), .mem_rd(mem_rd), .exc_req(exc_req),
        .pc(pc), .pc_plus4(pc_plus4), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .stall_cnt(stall_cnt), .state_o(state_o)
    );

    pc_flow_ctrl #(.DELAY_SLOT(1'b0)) dut_nds (
        .clock(clock), .reset(reset), .imem_ready(imem_ready),
        .id_valid(id_valid), .id_is_flow(id_is_flow), .id_taken(id_taken),
        .id_target(id_target), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_is_load(mem_is_load), .mem_rd(mem_rd), .exc_req(exc_req),
        .pc(pc_n), .pc_plus4(pc_plus4_n), .if_id_write(if_id_write_n),
        .if_id_flush(if_id_flush_n), .id_ex_bubble(id_ex_bubble_n),
        .stall_cnt(stall_cnt_n), .state_o(state_n)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        imem_ready  = 1'b0;
        id_valid    = 1'b0;
        id_is_flow  = 1'b0;
        id_taken    = 1'b0;
        id_target   = 32'h0;
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        id_uses_rs  = 1'b0;
        id_uses_rt  = 1'b0;
        ex_regwrite = 1'b0;
        ex_is_load  = 1'b0;
        ex_rd       = 5'd0;
        mem_is_load = 1'b0;
        mem_rd      = 5'd0;
        exc_req     = 1'b0;
    endtask

    task automatic clear_ex_mem();
        ex_regwrite = 1'b0;
        ex_is_load  = 1'b0;
        ex_rd       = 5'd0;
        mem_is_load = 1'b0;
        mem_rd      = 5'd0;
    endtask

    task automatic set_flow(input logic taken, input logic [31:0] target);
        id_valid   = 1'b1;
        id_is_flow = 1'b1;
        id_taken   = taken;
        id_target  = target;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        // Reset must win over a pending exception and a taken branch.
        exc_req    = 1'b1;
        imem_ready = 1'b1;
        set_flow(1'b1, 32'h0000_5000);
        tick();
        tick();
        settle();
        total++; if (pc !== 32'h0000_3000) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0000_3000); else passed++;
        total++; if (state_o !== 2'b00) $display("FAIL reset_state got=%b exp=00", state_o); else passed++;
        total++; if (stall_cnt !== 2'd0) $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); else passed++;
        total++; if (if_id_write !== 1'b0) $display("FAIL reset_write got=%b exp=0", if_id_write); else passed++;
        total++; if (if_id_flush !== 1'b1) $display("FAIL reset_flush got=%b exp=1", if_id_flush); else passed++;
        total++; if (id_ex_bubble !== 1'b1) $display("FAIL reset_bubble got=%b exp=1", id_ex_bubble); else passed++;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        imem_ready = 1'b1;
        settle();
        total++; if (if_id_write !== 1'b1) $display("FAIL seq_write got=%b exp=1", if_id_write); else passed++;
        total++; if (if_id_flush !== 1'b0) $display("FAIL seq_flush got=%b exp=0", if_id_flush); else passed++;
        total++; if (pc !== 32'h0000_3000) $display("FAIL seq_pc0 got=%h exp=%h", pc, 32'h0000_3000); else passed++;
        exp_pc = 32'h0000_3000;
        for (int i = 0; i < 3; i++) begin
            total++; if (pc_plus4 !== exp_pc + 32'd4) $display("FAIL seq_plus4 got=%h exp=%h", pc_plus4, exp_pc + 32'd4); else passed++;
            tick();
            exp_pc = exp_pc + 32'd4;
            total++; if (pc !== exp_pc) $display("FAIL seq_pc got=%h exp=%h", pc, exp_pc); else passed++;
        end
    endtask

    task automatic test_taken_redirect();
        // pc is 0x300C here
        imem_ready = 1'b1;
        set_flow(1'b1, 32'h0000_3040);
        settle();
        total++; if (if_id_write !== 1'b1) $display("FAIL br_write got=%b exp=1", if_id_write); else passed++;
        total++; if (if_id_flush !== 1'b0) $display("FAIL br_flush_ds got=%b exp=0", if_id_flush); else passed++;
        total++; if (if_id_flush_n !== 1'b1) $display("FAIL br_flush_nds got=%b exp=1", if_id_flush_n); else passed++;
        total++; if (id_ex_bubble !== 1'b0) $display("FAIL br_bubble got=%b exp=0", id_ex_bubble); else passed++;
        tick();
        total++; if (pc !== 32'h0000_3040) $display("FAIL br_pc got=%h exp=%h", pc, 32'h0000_3040); else passed++;
        total++; if (pc_n !== 32'h0000_3040) $display("FAIL br_pc_nds got=%h exp=%h", pc_n, 32'h0000_3040); else passed++;
    endtask

    task automatic test_not_taken();
        set_flow(1'b0, 32'h0000_3080);
        settle();
        total++; if (if_id_flush_n !== 1'b0) $display("FAIL nt_flush_nds got=%b exp=0", if_id_flush_n); else passed++;
        tick();
        total++; if (pc !== 32'h0000_3044) $display("FAIL nt_pc got=%h exp=%h", pc, 32'h0000_3044); else passed++;
    endtask

    task automatic test_load_hazard();
        // beq rs=8 while a load to r8 sits in EX
        imem_ready  = 1'b1;
        set_flow(1'b1, 32'h0000_3100);
        id_rs       = 5'd8;
        id_uses_rs  = 1'b1;
        ex_regwrite = 1'b1;
        ex_is_load  = 1'b1;
        ex_rd       = 5'd8;
        settle();
        total++; if (if_id_write !== 1'b0) $display("FAIL lh_write got=%b exp=0", if_id_write); else passed++;
        total++; if (id_ex_bubble !== 1'b1) $display("FAIL lh_bubble got=%b exp=1", id_ex_bubble); else passed++;
        tick();
        clear_ex_mem();
        total++; if (state_o !== 2'b01) $display("FAIL lh_state1 got=%b exp=01", state_o); else passed++;
        total++; if (stall_cnt !== 2'd2) $display("FAIL lh_cnt2 got=%0d exp=2", stall_cnt); else passed++;
        total++; if (pc !== 32'h0000_3044) $display("FAIL lh_pc1 got=%h exp=%h", pc, 32'h0000_3044); else passed++;
        settle();
        total++; if (id_ex_bubble !== 1'b1 || if_id_write !== 1'b0) $display("FAIL lh_haz_ctl got=%b%b exp=10", id_ex_bubble, if_id_write); else passed++;
        tick();
        total++; if (stall_cnt !== 2'd1) $display("FAIL lh_cnt1 got=%0d exp=1", stall_cnt); else passed++;
        total++; if (pc !== 32'h0000_3044) $display("FAIL lh_pc2 got=%h exp=%h", pc, 32'h0000_3044); else passed++;
        tick();
        total++; if (state_o !== 2'b00) $display("FAIL lh_state_run got=%b exp=00", state_o); else passed++;
        total++; if (stall_cnt !== 2'd0) $display("FAIL lh_cnt0 got=%0d exp=0", stall_cnt); else passed++;
        settle();
        total++; if (if_id_write !== 1'b1) $display("FAIL lh_resume_write got=%b exp=1", if_id_write); else passed++;
        tick();
        total++; if (pc !== 32'h0000_3100) $display("FAIL lh_target got=%h exp=%h", pc, 32'h0000_3100); else passed++;
        clear_inputs();
    endtask

    task automatic test_alu_hazard();
        // bne rt=9 with an ALU result to r9 in EX: one stall
        imem_ready  = 1'b1;
        set_flow(1'b0, 32'h0000_3200);
        id_rt       = 5'd9;
        id_uses_rt  = 1'b1;
        ex_regwrite = 1'b1;
        ex_rd       = 5'd9;
        tick();
        clear_ex_mem();
        total++; if (state_o !== 2'b01 || stall_cnt !== 2'd1) $display("FAIL alu_haz got=%b/%0d exp=01/1", state_o, stall_cnt); else passed++;
        tick();
        total++; if (state_o !== 2'b00 || pc !== 32'h0000_3100) $display("FAIL alu_back got=%b/%h exp=00/00003100", state_o, pc); else passed++;
        tick();
        total++; if (pc !== 32'h0000_3104) $display("FAIL alu_nt_pc got=%h exp=%h", pc, 32'h0000_3104); else passed++;
        // Same case against r0: no dependency
        id_rt       = 5'd0;
        ex_regwrite = 1'b1;
        ex_rd       = 5'd0;
        settle();
        total++; if (if_id_write !== 1'b1 || id_ex_bubble !== 1'b0) $display("FAIL r0_ctl got=%b%b exp=10", if_id_write, id_ex_bubble); else passed++;
        tick();
        total++; if (state_o !== 2'b00 || pc !== 32'h0000_3108) $display("FAIL r0_pc got=%b/%h exp=00/00003108", state_o, pc); else passed++;
        // MEM load dependency on rs: one stall
        clear_ex_mem();
        id_rt       = 5'd0;
        id_uses_rt  = 1'b0;
        id_rs       = 5'd5;
        id_uses_rs  = 1'b1;
        mem_is_load = 1'b1;
        mem_rd      = 5'd5;
        tick();
        clear_ex_mem();
        total++; if (state_o !== 2'b01 || stall_cnt !== 2'd1) $display("FAIL mem_haz got=%b/%0d exp=01/1", state_o, stall_cnt); else passed++;
        tick();
        clear_inputs();
    endtask

    task automatic test_imem_wait();
        // pc = 0x3108; taken jump to misaligned target while fetch stalls
        imem_ready = 1'b0;
        set_flow(1'b1, 32'h0000_3202);
        for (int i = 0; i < 3; i++) begin
            settle();
            total++; if (if_id_write !== 1'b0 || id_ex_bubble !== 1'b0) $display("FAIL wait_ctl got=%b%b exp=00", if_id_write, id_ex_bubble); else passed++;
            tick();
            total++; if (pc !== 32'h0000_3108) $display("FAIL wait_pc got=%h exp=%h", pc, 32'h0000_3108); else passed++;
        end
        imem_ready = 1'b1;
        tick();
        total++; if (pc !== 32'h0000_3200) $display("FAIL wait_redirect got=%h exp=%h", pc, 32'h0000_3200); else passed++;
        clear_inputs();
    endtask

    task automatic test_exc_drop();
        imem_ready  = 1'b1;
        set_flow(1'b1, 32'h0000_3300);
        id_rs       = 5'd8;
        id_uses_rs  = 1'b1;
        ex_regwrite = 1'b1;
        ex_is_load  = 1'b1;
        ex_rd       = 5'd8;
        tick();
        total++; if (state_o !== 2'b01) $display("FAIL exc_pre_haz got=%b exp=01", state_o); else passed++;
        clear_inputs();
        exc_req = 1'b1;
        settle();
        total++; if (if_id_write !== 1'b0 || if_id_flush !== 1'b1 || id_ex_bubble !== 1'b1) $display("FAIL exc_ctl got=%b%b%b exp=011", if_id_write, if_id_flush, id_ex_bubble); else passed++;
        tick();
        exc_req = 1'b0;
        total++; if (pc !== 32'h0000_4180) $display("FAIL exc_pc got=%h exp=%h", pc, 32'h0000_4180); else passed++;
        total++; if (stall_cnt !== 2'd0) $display("FAIL exc_cnt got=%0d exp=0", stall_cnt); else passed++;
        total++; if (state_o !== 2'b10) $display("FAIL exc_state got=%b exp=10", state_o); else passed++;
        settle();
        total++; if (if_id_flush !== 1'b0) $display("FAIL drop_wait_flush got=%b exp=0", if_id_flush); else passed++;
        tick();
        total++; if (state_o !== 2'b10) $display("FAIL drop_hold got=%b exp=10", state_o); else passed++;
        imem_ready = 1'b1;
        settle();
        total++; if (if_id_flush !== 1'b1 || if_id_write !== 1'b0) $display("FAIL drop_beat got=%b%b exp=10", if_id_flush, if_id_write); else passed++;
        tick();
        total++; if (state_o !== 2'b00 || pc !== 32'h0000_4180) $display("FAIL drop_exit got=%b/%h exp=00/00004180", state_o, pc); else passed++;
        tick();
        total++; if (pc !== 32'h0000_4184) $display("FAIL drop_adv got=%h exp=%h", pc, 32'h0000_4184); else passed++;
    endtask

    task automatic test_exc_ready_and_wrap();
        // Exception with ready high goes straight to RUN
        imem_ready = 1'b1;
        exc_req    = 1'b1;
        tick();
        exc_req = 1'b0;
        total++; if (state_o !== 2'b00 || pc !== 32'h0000_4180) $display("FAIL exc_rdy got=%b/%h exp=00/00004180", state_o, pc); else passed++;
        set_flow(1'b1, 32'hFFFF_FFFC);
        tick();
        clear_inputs();
        imem_ready = 1'b1;
        settle();
        total++; if (pc_plus4 !== 32'h0000_0000) $display("FAIL wrap_plus4 got=%h exp=00000000", pc_plus4); else passed++;
        tick();
        total++; if (pc !== 32'h0000_0000) $display("FAIL wrap_pc got=%h exp=00000000", pc); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_taken_redirect();
        test_not_taken();
        test_load_hazard();
        test_alu_hazard();
        test_imem_wait();
        test_exc_drop();
        test_exc_ready_and_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_flow_ctrl.md
Name: pc_flow_ctrl

Overview:
- Sequences the fetch-stage program counter.
- Owns the PC register and selects the next PC:
  - sequential pc+4,
  - an ID-resolved branch/jump target,
  - the exception vector.
- Generates the IF/ID hold, IF/ID flush and ID/EX bubble controls around the ID-stage branch-resolution path.
- Enforces a counted stall when a branch/jump in ID depends on a result still in EX/MEM.
- Obeys the instruction-memory ready handshake, including discard of a stale fetch after an exception redirect.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- DELAY_SLOT, 1, 1 = the instruction behind a taken branch is kept (MIPS delay slot); 0 = it is flushed.
- EXC_VECTOR, 32'h0000_4180, target loaded on exc_req.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_ready  in  1  fetch of the current pc completes this cycle.
- id_valid  in  1  ID holds a real instruction.
- id_is_flow  in  1  ID instruction is a branch/jump (beq/bne/bgtz/blez/bgez/bltz/j/jal/jr/jalr).
- id_taken  in  1  ID compare/decode resolved the flow instruction as taken (always 1 for jumps).
- id_target  in  32  resolved branch/jump target.
- id_rs  in  5  ID source register field.
- id_rt  in  5  ID source register field.
- id_uses_rs  in  1  flow instruction reads rs.
- id_uses_rt  in  1  flow instruction reads rt.
- ex_regwrite  in  1  EX instruction writes a register.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- mem_is_load  in  1  MEM instruction is a load.
- mem_rd  in  5  MEM destination register.
- exc_req  in  1  exception redirect request, single-cycle pulse.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID register loads a bubble.
- id_ex_bubble  out  1  ID/EX register loads a bubble.
- stall_cnt  out  2  remaining branch-hazard stall cycles.
- state_o  out  2  FSM state (00 RUN, 01 HAZ, 10 DROP).

Behaviour:
- Reset: pc=RESET_PC; state=RUN; stall_cnt=0; if_id_write=0; if_id_flush=1; id_ex_bubble=1. Reset wins over every other input.
- Dependency match, evaluated against rs (when id_uses_rs) and rt (when id_uses_rt): reg!=0 and reg==ex_rd with ex_regwrite, or reg==mem_rd with mem_is_load.
- Required stall depth:
  - 2 if the match is in EX and ex_is_load.
  - else 1 if the match is EX ALU or MEM load.
  - else 0.
- RUN:
  - If id_valid&&id_is_flow and depth>0: load stall_cnt=depth, go to HAZ, no PC update.
  - Otherwise, when imem_ready=1: pc <= (id_valid&&id_is_flow&&id_taken) ? id_target : pc+4.
  - When imem_ready=0: pc holds and the branch stays in ID; the redirect is applied only on a cycle with imem_ready=1.
- HAZ:
  - Each cycle: if_id_write=0, pc holds, id_ex_bubble=1, stall_cnt decrements.
  - When stall_cnt reaches 0, return to RUN; the branch re-resolves there with forwarded operands.
  - New dependency checks are not performed inside HAZ.
- DROP:
  - Entered when exc_req arrives while imem_ready=0 (a stale fetch is in flight).
  - pc <= EXC_VECTOR immediately.
  - The next imem_ready=1 beat is discarded (if_id_flush=1, pc unchanged that cycle); then return to RUN.
- exc_req:
  - Highest priority in any state: pc <= EXC_VECTOR, stall_cnt <= 0, if_id_flush=1, id_ex_bubble=1.
  - Next state is DROP if imem_ready=0, else RUN.
- Per-cycle control outputs:
  - if_id_write=1 only in RUN with imem_ready=1 and no hazard.
  - if_id_write=0 during HAZ, imem_ready=0, DROP and exc_req.
- Taken redirect:
  - DELAY_SLOT=1: IF/ID captures the sequential instruction (delay slot) normally.
  - DELAY_SLOT=0: if_id_flush=1 in the redirect cycle.
- Not-taken flow instruction: plain pc+4, no flush.
- Arithmetic: pc_plus4 is a 32-bit add that wraps at 32'hFFFF_FFFC -> 0.
- Alignment: pc[1:0] is forced to 0 on load.
- Stalled ID: id_ex_bubble=1 whenever if_id_write=0 due to a hazard; it is 0 on imem_ready=0 alone.

Test Plan:
- Reset then 3 cycles of imem_ready=1 with no flow -> pc 0x3000, 0x3004, 0x3008, 0x300C; if_id_write=1 after reset deasserts.
- beq taken in ID, id_target=0x3040, no hazard, DELAY_SLOT=1 -> next pc=0x3040, if_id_flush=0; with DELAY_SLOT=0 -> if_id_flush=1 in that cycle.
- beq rs=8 with EX load rd=8 -> HAZ with stall_cnt 2 then 1, id_ex_bubble=1, pc held for 2 cycles; then RUN redirects to target.
- bne rt=9 with EX ALU rd=9 -> 1 stall cycle; the same case with rd=0 -> no stall.
- Taken jump while imem_ready=0 for 3 cycles -> pc held and branch held in ID; redirect happens on the first cycle with imem_ready=1.
- exc_req while imem_ready=0 during HAZ -> pc=0x4180, stall_cnt=0, state DROP; next ready beat flushed; then pc advances 0x4184.
